// File: rtl/decode_stage_piped.sv
// decode_stage_piped
//   RV32 decode stage with its D->E pipeline register. Decodes instr_D,
//   reads the register file (with write-stage bypass), detects load-use
//   hazards, and registers everything into the E stage.
// Ports
//   clk, rst_n                 clock, async active-low reset
//   instr_D/pc_D/pcPlus4_D     instruction and PCs from the F/D register
//   valid_D                    instr_D is real (0 = bubble)
//   flush_E                    squash the instruction entering E
//   regWrite_W/Rd_W/result_W   writeback port
//   stall_FD                   hold PC and F/D register
//   *_E                        registered control, indices, operands, PCs
//   a0                         x10 contents (not bypassed)
// Encodings
//   resultSrc : 00 ALU, 01 load data, 10 pc+4, 11 immediate (lui)
//   ALUctrl   : {funct7[5], funct3} for ALU ops (add 0000, sub 1000,
//               sra 1101, ...); 1111 = pc + imm (auipc)
//   branch    : 000 none, 010 beq, otherwise funct3 (bne 001, blt 100, ...)
//   jump      : 1 for jal/jalr; jalr additionally has ALUsrc=1
//   R_size / DMem_size : funct3 of the load / store
//   ImmExt is 0 for R-type.
module decode_stage_piped #(
  parameter int WIDTH          = 32,
  parameter int NUM_REGS       = 32,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_D,
  input  logic [WIDTH-1:0] pc_D,
  input  logic [WIDTH-1:0] pcPlus4_D,
  input  logic             valid_D,
  input  logic             flush_E,
  input  logic             regWrite_W,
  input  logic [4:0]       Rd_W,
  input  logic [WIDTH-1:0] result_W,
  output logic             stall_FD,
  output logic             valid_E,
  output logic             regWrite_E,
  output logic [1:0]       resultSrc_E,
  output logic             jump_E,
  output logic [2:0]       branch_E,
  output logic [3:0]       ALUctrl_E,
  output logic             ALUsrc_E,
  output logic [2:0]       R_size_E,
  output logic [2:0]       DMem_size_E,
  output logic [4:0]       Rd_E,
  output logic [4:0]       Rs1_E,
  output logic [4:0]       Rs2_E,
  output logic [WIDTH-1:0] RD1_E,
  output logic [WIDTH-1:0] RD2_E,
  output logic [WIDTH-1:0] ImmExt_E,
  output logic [WIDTH-1:0] pc_E,
  output logic [WIDTH-1:0] pcPlus4_E,
  output logic [WIDTH-1:0] a0
);
  localparam int IW = $clog2(NUM_REGS);

  typedef struct packed {
    logic             valid;
    logic             regWrite;
    logic [1:0]       resultSrc;
    logic             jump;
    logic [2:0]       branch;
    logic [3:0]       ALUctrl;
    logic             ALUsrc;
    logic [2:0]       R_size;
    logic [2:0]       DMem_size;
    logic [4:0]       Rd;
    logic [4:0]       Rs1;
    logic [4:0]       Rs2;
    logic [WIDTH-1:0] RD1;
    logic [WIDTH-1:0] RD2;
    logic [WIDTH-1:0] ImmExt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcPlus4;
  } e_t;

  // ---------------- register file ----------------
  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic [4:0]       w_rs1, w_rs2;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_rd1, w_rd2;

  assign w_rs1   = instr_D[19:15];
  assign w_rs2   = instr_D[24:20];
  assign w_wr_ok = regWrite_W && (Rd_W != 5'd0) && (32'(Rd_W) < NUM_REGS);

  // x0 is never written, so r_regs[0] stays zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[Rd_W[IW-1:0]] <= result_W;
    end
  end

  // Out-of-range indices read 0 even when a writeback targets them.
  always_comb begin
    w_rd1 = r_regs[w_rs1[IW-1:0]];
    if (w_rs1 == 5'd0 || 32'(w_rs1) >= NUM_REGS) w_rd1 = '0;
    else if (regWrite_W && Rd_W == w_rs1)        w_rd1 = result_W;
  end

  always_comb begin
    w_rd2 = r_regs[w_rs2[IW-1:0]];
    if (w_rs2 == 5'd0 || 32'(w_rs2) >= NUM_REGS) w_rd2 = '0;
    else if (regWrite_W && Rd_W == w_rs2)        w_rd2 = result_W;
  end

  assign a0 = r_regs[10];

  // ---------------- immediates ----------------
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  assign w_imm_i = {{20{instr_D[31]}}, instr_D[31:20]};
  assign w_imm_s = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
  assign w_imm_b = {{19{instr_D[31]}}, instr_D[31], instr_D[7], instr_D[30:25],
                    instr_D[11:8], 1'b0};
  assign w_imm_u = {instr_D[31:12], 12'd0};
  assign w_imm_j = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12], instr_D[20],
                    instr_D[30:21], 1'b0};

  // ---------------- control decode ----------------
  logic [6:0] w_op;
  logic [2:0] w_f3;
  e_t         w_d;
  assign w_op = instr_D[6:0];
  assign w_f3 = instr_D[14:12];

  always_comb begin
    w_d         = '0;
    w_d.valid   = valid_D;
    w_d.Rd      = instr_D[11:7];
    w_d.Rs1     = w_rs1;
    w_d.Rs2     = w_rs2;
    w_d.RD1     = w_rd1;
    w_d.RD2     = w_rd2;
    w_d.pc      = pc_D;
    w_d.pcPlus4 = pcPlus4_D;
    // An invalid slot keeps its data fields but carries no control.
    if (valid_D) begin
      case (w_op)
        7'b0110011: begin
          w_d.regWrite = 1'b1;
          w_d.ALUctrl  = {instr_D[30], w_f3};
        end
        7'b0010011: begin
          w_d.regWrite = 1'b1;
          w_d.ALUsrc   = 1'b1;
          // funct7[5] only selects srai among immediate ops
          w_d.ALUctrl  = {instr_D[30] & (w_f3 == 3'b101), w_f3};
          w_d.ImmExt   = WIDTH'($signed(w_imm_i));
        end
        7'b0000011: begin
          w_d.regWrite  = 1'b1;
          w_d.resultSrc = 2'b01;
          w_d.ALUsrc    = 1'b1;
          w_d.R_size    = w_f3;
          w_d.ImmExt    = WIDTH'($signed(w_imm_i));
        end
        7'b0100011: begin
          w_d.ALUsrc    = 1'b1;
          w_d.DMem_size = w_f3;
          w_d.ImmExt    = WIDTH'($signed(w_imm_s));
        end
        7'b1100011: begin
          // beq has funct3 000, which would collide with "no branch"
          w_d.branch  = (w_f3 == 3'b000) ? 3'b010 : w_f3;
          w_d.ALUctrl = 4'b1000;
          w_d.ImmExt  = WIDTH'($signed(w_imm_b));
        end
        7'b1101111: begin
          w_d.regWrite  = 1'b1;
          w_d.resultSrc = 2'b10;
          w_d.jump      = 1'b1;
          w_d.ImmExt    = WIDTH'($signed(w_imm_j));
        end
        7'b1100111: begin
          w_d.regWrite  = 1'b1;
          w_d.resultSrc = 2'b10;
          w_d.jump      = 1'b1;
          w_d.ALUsrc    = 1'b1;
          w_d.ImmExt    = WIDTH'($signed(w_imm_i));
        end
        7'b0110111: begin
          w_d.regWrite  = 1'b1;
          w_d.resultSrc = 2'b11;
          w_d.ALUsrc    = 1'b1;
          w_d.ImmExt    = WIDTH'($signed(w_imm_u));
        end
        7'b0010111: begin
          w_d.regWrite = 1'b1;
          w_d.ALUctrl  = 4'b1111;
          w_d.ALUsrc   = 1'b1;
          w_d.ImmExt   = WIDTH'($signed(w_imm_u));
        end
        default: ;
      endcase
    end
  end

  // ---------------- hazard + E register ----------------
  e_t   r_e;
  logic w_load_use;

  assign w_load_use = r_e.valid && (r_e.resultSrc == 2'b01) && (r_e.Rd != 5'd0) &&
                      valid_D && ((w_rs1 == r_e.Rd) || (w_rs2 == r_e.Rd));
  assign stall_FD   = (LOAD_USE_STALL != 0) && w_load_use && !flush_E;

  // Flush and stall both insert an all-zero bubble; during a stall the
  // F/D register holds, so instr_D is re-decoded on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_e <= '0;
    else if (flush_E || stall_FD)  r_e <= '0;
    else                           r_e <= w_d;
  end

  assign valid_E     = r_e.valid;
  assign regWrite_E  = r_e.regWrite;
  assign resultSrc_E = r_e.resultSrc;
  assign jump_E      = r_e.jump;
  assign branch_E    = r_e.branch;
  assign ALUctrl_E   = r_e.ALUctrl;
  assign ALUsrc_E    = r_e.ALUsrc;
  assign R_size_E    = r_e.R_size;
  assign DMem_size_E = r_e.DMem_size;
  assign Rd_E        = r_e.Rd;
  assign Rs1_E       = r_e.Rs1;
  assign Rs2_E       = r_e.Rs2;
  assign RD1_E       = r_e.RD1;
  assign RD2_E       = r_e.RD2;
  assign ImmExt_E    = r_e.ImmExt;
  assign pc_E        = r_e.pc;
  assign pcPlus4_E   = r_e.pcPlus4;
endmodule
